// File: rtl/fc_mac_ctrl_pkg.sv
// rtl/fc_mac_ctrl_pkg.sv - shared sizes and FSM encoding for the FC MAC controller and datapath
package fc_mac_ctrl_pkg;
  localparam int FEAT_W = 108;
  localparam int LANES  = 3;
  localparam int BEATS  = FEAT_W / LANES;
  localparam int ACC_W  = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    CLEAR = S_CLEAR,
    RUN   = S_RUN,
    DRAIN = S_DRAIN,
    OUT   = S_OUT
  } fc_state_e;
endpackage

// File: rtl/fc_feat_shifter.sv
// rtl/fc_feat_shifter.sv - lane-sliced feature shift register; each lane emits its slice MSB-first
module fc_feat_shifter #(
  parameter int FEAT_W = 108,
  parameter int LANES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [FEAT_W-1:0] feat_in,
  output logic [LANES-1:0]  lanes
);
  localparam int BEATS = FEAT_W / LANES;

  logic [FEAT_W-1:0] feat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q <= '0;
    end else if (load) begin
      feat_q <= feat_in;
    end else if (shift) begin
      for (int j = 0; j < LANES; j++) begin
        feat_q[j*BEATS +: BEATS] <= {feat_q[j*BEATS +: BEATS-1], 1'b0};
      end
    end
  end

  // After k shifts the top of slice j holds original bit (j+1)*BEATS-1-k.
  always_comb begin
    lanes = '0;
    for (int j = 0; j < LANES; j++) begin
      lanes[j] = feat_q[(j+1)*BEATS-1];
    end
  end
endmodule

// File: rtl/fc_mac_ctrl.sv
// rtl/fc_mac_ctrl.sv - sequences one binary-feature inference through the MAC datapath
module fc_mac_ctrl #(
  parameter int FEAT_W = fc_mac_ctrl_pkg::FEAT_W,
  parameter int LANES  = fc_mac_ctrl_pkg::LANES,
  parameter int ACC_W  = fc_mac_ctrl_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [FEAT_W-1:0]       feat_in,
  input  logic                    abort,
  output logic [LANES-1:0]        mac_in,
  output logic                    mac_en,
  output logic                    mac_clr,
  input  logic signed [ACC_W-1:0] acc1,
  input  logic signed [ACC_W-1:0] acc2,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_out,
  output logic                    busy,
  output logic [5:0]              beat_idx
);
  import fc_mac_ctrl_pkg::*;

  localparam int          NBEATS    = FEAT_W / LANES;
  localparam logic [5:0]  LAST_BEAT = 6'(NBEATS - 1);

  logic [2:0]       state;
  logic [LANES-1:0] lanes;

  assign start_ready = (state == S_IDLE);
  assign mac_clr     = (state == S_CLEAR);
  assign mac_en      = (state == S_RUN);
  assign res_valid   = (state == S_OUT);
  assign busy        = (state != S_IDLE);
  assign mac_in      = mac_en ? lanes : '0;

  fc_feat_shifter #(
    .FEAT_W (FEAT_W),
    .LANES  (LANES)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ready && start_valid),
    .shift   (mac_en),
    .feat_in (feat_in),
    .lanes   (lanes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_idx <= '0;
      res_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) state <= S_CLEAR;
        end
        S_CLEAR: begin
          beat_idx <= '0;
          state    <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            state    <= S_IDLE;
            beat_idx <= '0;
          end else if (beat_idx == LAST_BEAT) begin
            state    <= S_DRAIN;
            beat_idx <= '0;
          end else begin
            beat_idx <= beat_idx + 6'd1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            // Class sign bits: non-negative accumulator reads as 1.
            res_out <= {~acc1[ACC_W-1], ~acc2[ACC_W-1]};
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_mac_ctrl.sv
// tb/tb_fc_mac_ctrl.sv - scoreboard bench for fc_mac_ctrl with a bit-level reference model
module tb_fc_mac_ctrl;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [107:0]      feat_in = '0;
  logic              abort = 1'b0;
  logic [2:0]        mac_in;
  logic              mac_en;
  logic              mac_clr;
  logic signed [7:0] acc1 = '0;
  logic signed [7:0] acc2 = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [1:0]        res_out;
  logic              busy;
  logic [5:0]        beat_idx;

  fc_mac_ctrl dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .feat_in(feat_in), .abort(abort), .mac_in(mac_in), .mac_en(mac_en),
    .mac_clr(mac_clr), .acc1(acc1), .acc2(acc2), .res_valid(res_valid),
    .res_ready(res_ready), .res_out(res_out), .busy(busy), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [107:0] feat;
    logic [1:0]   res;
    int           t;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   beat_cnt = 0;
  bit   seen_valid = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Beat k carries bit k counted from the top of each third of the vector.
  function automatic logic [2:0] model_beat(input logic [107:0] f, input int k);
    return {f[107-k], f[71-k], f[35-k]};
  endfunction

  function automatic logic [1:0] model_res(input int a1, input int a2);
    return {a1 >= 0, a2 >= 0};
  endfunction

  function automatic logic [107:0] rand_feat();
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    return w[107:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mac_clr) begin
        if (q.size() == 0) chk("mac_clr_unexpected", 1, 0);
        else chk("mac_clr_cycle", cyc - q[0].t, 1);
        beat_cnt = 0;
      end
      if (mac_en) begin
        if (q.size() == 0) chk("mac_en_unexpected", 1, 0);
        else if (beat_cnt >= 36) chk("extra_beat", beat_cnt, 35);
        else begin
          chk("mac_in", mac_in, model_beat(q[0].feat, beat_cnt));
          chk("beat_idx", beat_idx, beat_cnt);
        end
        beat_cnt++;
      end else begin
        chk("mac_in_quiet", mac_in, 0);
      end
      if (res_valid) begin
        if (q.size() == 0) chk("res_valid_unexpected", 1, 0);
        else begin
          if (!seen_valid) begin
            chk("latency", cyc - q[0].t, 39);
            seen_valid = 1;
          end
          chk("res_out", res_out, q[0].res);
          chk("start_ready_in_out", start_ready, 0);
          if (res_ready) begin
            chk("beats_per_inference", beat_cnt, 36);
            void'(q.pop_front());
            seen_valid = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle_start(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = start_ready;
    if (!ok) chk("timeout_start_ready", 0, 1);
  endtask

  task automatic issue(input logic [107:0] f, input int a1, input int a2, input bit ab);
    exp_t e;
    feat_in = f;
    acc1 = 8'(a1);
    acc2 = 8'(a2);
    start_valid = 1'b1;
    abort = ab;
    e.feat = f;
    e.res  = model_res(a1, a2);
    e.t    = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    abort = 1'b0;
    feat_in = rand_feat();
  endtask

  task automatic run_one(input logic [107:0] f, input int a1, input int a2,
                         input int hold, input bit ab_start, input bit pulse_out);
    bit ok;
    int n;
    wait_idle_start(ok);
    if (!ok) return;
    res_ready = (hold == 0);
    issue(f, a1, a2, ab_start);
    if (hold > 0) begin
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!res_valid) chk("timeout_res_valid", 0, 1);
      for (int h = 0; h < hold; h++) begin
        start_valid = pulse_out && (h == 1);
        abort       = pulse_out && (h == 2);
        feat_in     = ~f;
        @(negedge clk);
        chk("res_valid_held", res_valid, 1);
      end
      start_valid = 1'b0;
      abort = 1'b0;
      res_ready = 1'b1;
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout_result", 0, 1);
      q.delete();
    end
    res_ready = 1'b1;
  endtask

  // at_beat < 0 cancels in CLEAR; use_rst selects reset instead of abort.
  task automatic run_cancel(input logic [107:0] f, input int at_beat, input bit use_rst);
    bit ok;
    int n = 0;
    wait_idle_start(ok);
    if (!ok) return;
    issue(f, 5, 5, 1'b0);
    @(negedge clk);
    while (n < 100 && !(at_beat < 0 ? mac_clr : (mac_en && beat_idx == 6'(at_beat)))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout_cancel_point", 0, 1);
    if (use_rst) begin
      rst = 1'b1;
      #1;
      q.delete();
      chk("rst_mac_en", mac_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_beat_idx", beat_idx, 0);
      chk("rst_start_ready", start_ready, 1);
      chk("rst_mac_in", mac_in, 0);
      chk("rst_res_valid", res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      q.delete();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cancel_mac_en", mac_en, 0);
      chk("cancel_busy", busy, 0);
      chk("cancel_res_valid", res_valid, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_start_ready", start_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_mac_en", mac_en, 0);
    chk("reset_mac_clr", mac_clr, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_out", res_out, 0);
    chk("reset_beat_idx", beat_idx, 0);
    chk("reset_mac_in", mac_in, 0);
    rst = 1'b0;

    run_one({108{1'b1}}, 20, -4, 0, 1'b0, 1'b0);
    run_one(108'd1 << 107, 3, 3, 0, 1'b0, 1'b0);
    run_one(108'd1, -3, 3, 0, 1'b0, 1'b0);
    run_one(rand_feat(), 7, -7, 5, 1'b0, 1'b1);
    run_cancel(rand_feat(), 20, 1'b0);
    run_one(rand_feat(), -50, 60, 0, 1'b0, 1'b0);
    run_cancel(rand_feat(), -1, 1'b0);
    run_one(rand_feat(), 0, -1, 0, 1'b0, 1'b0);
    run_one(rand_feat(), -128, 127, 0, 1'b1, 1'b0);
    run_cancel(rand_feat(), 10, 1'b1);
    run_one(rand_feat(), 1, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_one(rand_feat(), int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
              int'($urandom_range(3)), 1'b0, 1'(i % 2));
    end
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
